// File: rtl/inst_cmd_queue_pkg.sv
// Shared EAI definitions: payload field width, default queue depth and the
// fixed {inst, rs1, rs2} packing order used by both the queue and the executor.
package inst_cmd_queue_pkg;

  // Width of each individual field (inst, rs1, rs2).
  localparam int unsigned EAI_DW            = 32;
  // Default number of queued entries.
  localparam int unsigned EAI_DEFAULT_DEPTH = 4;
  // Number of fields carried per entry.
  localparam int unsigned EAI_NUM_FIELDS    = 3;

  // Field slots inside a packed payload; slot n occupies bits [n*DW +: DW].
  // inst sits in the most significant slot, rs2 in the least.
  localparam int unsigned EAI_SLOT_INST = 2;
  localparam int unsigned EAI_SLOT_RS1  = 1;
  localparam int unsigned EAI_SLOT_RS2  = 0;

  // Total packed payload width for a given field width.
  function automatic int unsigned eai_payload_w(input int unsigned dw);
    return EAI_NUM_FIELDS * dw;
  endfunction

endpackage

// File: rtl/inst_cmd_queue.sv
// Parametrised FIFO of {inst, rs1, rs2} entries between EAI decode and the
// accelerator command executor, with synchronous flush, occupancy count and
// an almost-full flag derived from registered state only.
module inst_cmd_queue
  import inst_cmd_queue_pkg::*;
#(
  parameter int unsigned DW       = EAI_DW,
  parameter int unsigned DEPTH    = EAI_DEFAULT_DEPTH,
  parameter int unsigned AFULL_TH = DEPTH - 1,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_inst,
  input  logic [DW-1:0] wr_rs1,
  input  logic [DW-1:0] wr_rs2,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_inst,
  output logic [DW-1:0] rd_rs1,
  output logic [DW-1:0] rd_rs2,
  output logic [CW-1:0] count,
  output logic          almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = eai_payload_w(DW);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic [EW-1:0] wr_payload;
  logic [EW-1:0] rd_payload;
  logic          wr_fire;
  logic          rd_fire;

  // Handshake qualifiers; flush forces both sides idle for the cycle.
  always_comb begin
    wr_ready = (count_q != CW'(DEPTH)) & ~flush;
    rd_valid = (count_q != '0) & ~flush;
    wr_fire  = wr_valid & wr_ready;
    rd_fire  = rd_valid & rd_ready;
  end

  // Pack the incoming entry and unpack the head entry in the shared slot order.
  always_comb begin
    wr_payload = '0;
    wr_payload[EAI_SLOT_INST*DW +: DW] = wr_inst;
    wr_payload[EAI_SLOT_RS1*DW  +: DW] = wr_rs1;
    wr_payload[EAI_SLOT_RS2*DW  +: DW] = wr_rs2;
    rd_payload = mem_q[rd_ptr_q];
    rd_inst    = rd_payload[EAI_SLOT_INST*DW +: DW];
    rd_rs1     = rd_payload[EAI_SLOT_RS1*DW  +: DW];
    rd_rs2     = rd_payload[EAI_SLOT_RS2*DW  +: DW];
  end

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: cleared on reset, left untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_payload;
    end
  end

  // Status outputs come straight from the occupancy register.
  always_comb begin
    count       = count_q;
    almost_full = (count_q >= CW'(AFULL_TH));
  end

endmodule

// File: tb/tb_inst_cmd_queue.sv
// Self-checking bench for inst_cmd_queue: directed scenarios plus a long
// randomized run against a queue-based reference model.
module tb_inst_cmd_queue;

  localparam int DW       = 32;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 3;
  localparam int CW       = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] wr_inst = '0, wr_rs1 = '0, wr_rs2 = '0;
  logic          wr_ready, rd_valid, almost_full;
  logic [DW-1:0] rd_inst, rd_rs1, rd_rs2;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: entries in FIFO order, each {inst, rs1, rs2}.
  logic [3*DW-1:0] mq[$];

  always #5 clk = ~clk;

  inst_cmd_queue #(.DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_inst(wr_inst), .wr_rs1(wr_rs1), .wr_rs2(wr_rs2),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_inst(rd_inst), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .count(count), .almost_full(almost_full)
  );

  // Apply the clock edge to the model using the current inputs, then move
  // to the next negative edge where stimulus is changed and outputs sampled.
  task automatic tick();
    bit wf, rf;
    if (rst || flush) begin
      mq.delete();
    end else begin
      wf = wr_valid && (mq.size() != DEPTH);
      rf = rd_ready && (mq.size() != 0);
      if (rf) void'(mq.pop_front());
      if (wf) mq.push_back({wr_inst, wr_rs1, wr_rs2});
    end
    @(negedge clk);
  endtask

  task automatic put(input logic [DW-1:0] inst, input logic [DW-1:0] rs1, input logic [DW-1:0] rs2);
    wr_inst = inst; wr_rs1 = rs1; wr_rs2 = rs2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
    n_cmp++; if (rd_inst !== 32'h0 || rd_rs1 !== 32'h0 || rd_rs2 !== 32'h0) begin
      n_bad++; $display("FAIL reset_rd_data: got %h/%h/%h want 0/0/0", rd_inst, rd_rs1, rd_rs2);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] e;
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(i, 32'h100 + i, 32'h200 + i);
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fill_wr_ready[%0d]: got %b want 1", i, wr_ready); end
      tick(); #1;
      n_cmp++; if (count !== CW'(i)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
      n_cmp++; if (almost_full !== (i >= 3)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, i >= 3); end
    end
    // Fifth entry is presented and must be held while full.
    put(32'h5, 32'h105, 32'h205);
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
    tick(); #1;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_hold_count: got %0d want 4", count); end
    rd_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      e = k;
      n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL drain_rd_valid[%0d]: got %b want 1", k, rd_valid); end
      n_cmp++; if (rd_inst !== e || rd_rs1 !== 32'h100 + e || rd_rs2 !== 32'h200 + e) begin
        n_bad++; $display("FAIL drain_data[%0d]: got %h/%h/%h want %h/%h/%h", k, rd_inst, rd_rs1, rd_rs2, e, 32'h100 + e, 32'h200 + e);
      end
      if (k <= 2) begin
        n_cmp++; if (wr_ready !== (k != 1)) begin n_bad++; $display("FAIL drain_wr_ready[%0d]: got %b want %b", k, wr_ready, k != 1); end
      end
      tick();
      if (k == 2) wr_valid = 1'b0;
    end
    rd_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got count=%0d rd_valid=%b want 0/0", count, rd_valid); end
  endtask

  task automatic test_back_to_back();
    int wseq = 0;
    int rseq = 0;
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put(32'h10 + wseq, 32'h1000 + wseq, 32'h2000 + wseq); wseq++;
      tick();
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      put(32'h10 + wseq, 32'h1000 + wseq, 32'h2000 + wseq); wseq++;
      #1;
      n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want 2", c, count); end
      n_cmp++; if (rd_valid !== 1'b1 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got rv=%b wr=%b want 1/1", c, rd_valid, wr_ready); end
      n_cmp++; if (rd_inst !== 32'(32'h10 + rseq) || rd_rs2 !== 32'(32'h2000 + rseq)) begin
        n_bad++; $display("FAIL b2b_order[%0d]: got %h/%h want %h/%h", c, rd_inst, rd_rs2, 32'h10 + rseq, 32'h2000 + rseq);
      end
      rseq++;
      tick();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (rd_inst !== 32'(32'h10 + rseq)) begin n_bad++; $display("FAIL b2b_tail[%0d]: got %h want %h", c, rd_inst, 32'h10 + rseq); end
      rseq++;
      tick();
    end
    rd_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL b2b_empty: got %0d want 0", count); end
  endtask

  task automatic test_full_read();
    logic [DW-1:0] exp_seq [5];
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(32'h30 + i, 32'h0, 32'h0); exp_seq[i] = 32'h30 + i;
      tick();
    end
    exp_seq[4] = 32'h40;
    put(32'h40, 32'h0, 32'h0);
    rd_ready = 1'b1;
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL fullrd_wr_ready: got %b want 0", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b1 || rd_inst !== 32'h30) begin n_bad++; $display("FAIL fullrd_head: got rv=%b inst=%h want 1/30", rd_valid, rd_inst); end
    tick();
    rd_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fullrd_count: got %0d want 3", count); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fullrd_next_wr_ready: got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fullrd_refill: got %0d want 4", count); end
    rd_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      n_cmp++; if (rd_inst !== exp_seq[k]) begin n_bad++; $display("FAIL fullrd_order[%0d]: got %h want %h", k, rd_inst, exp_seq[k]); end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_flush();
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(32'h50 + i, 32'h0, 32'h0);
      tick();
    end
    #1;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    flush = 1'b1; rd_ready = 1'b1; put(32'h77, 32'h0, 32'h0);
    #1;
    n_cmp++; if (wr_ready !== 1'b0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_gate: got wr=%b rv=%b want 0/0", wr_ready, rd_valid); end
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || rd_valid !== 1'b0 || almost_full !== 1'b0) begin
      n_bad++; $display("FAIL flush_after: got count=%0d rv=%b af=%b want 0/0/0", count, rd_valid, almost_full);
    end
    wr_valid = 1'b1; put(32'hAA, 32'hAB, 32'hAC);
    tick();
    wr_valid = 1'b0;
    #1;
    n_cmp++; if (rd_valid !== 1'b1 || rd_inst !== 32'hAA || rd_rs1 !== 32'hAB || rd_rs2 !== 32'hAC) begin
      n_bad++; $display("FAIL flush_newdata: got rv=%b %h/%h/%h want 1 aa/ab/ac", rd_valid, rd_inst, rd_rs1, rd_rs2);
    end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL flush_newcount: got %0d want 1", count); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_random();
    bit exp_wr, exp_rv;
    int wr_pct;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Alternate producer bias so both full and empty regions are exercised.
      wr_pct   = ((cyc / 400) % 2 == 0) ? 75 : 30;
      wr_valid = ($urandom_range(99) < wr_pct);
      rd_ready = ($urandom_range(99) < 50);
      flush    = ($urandom_range(199) == 0);
      rst      = ($urandom_range(999) == 0);
      put($urandom, $urandom, $urandom);
      #1;
      exp_wr = (mq.size() != DEPTH) && !flush;
      exp_rv = (mq.size() != 0) && !flush;
      n_cmp++; if (wr_ready !== exp_wr) begin n_bad++; $display("FAIL rnd_wr_ready@%0d: got %b want %b", cyc, wr_ready, exp_wr); end
      n_cmp++; if (rd_valid !== exp_rv) begin n_bad++; $display("FAIL rnd_rd_valid@%0d: got %b want %b", cyc, rd_valid, exp_rv); end
      n_cmp++; if (int'(count) != mq.size() || count > CW'(DEPTH)) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, mq.size()); end
      n_cmp++; if (almost_full !== (mq.size() >= AFULL_TH)) begin n_bad++; $display("FAIL rnd_afull@%0d: got %b want %b", cyc, almost_full, mq.size() >= AFULL_TH); end
      if (exp_rv) begin
        n_cmp++; if ({rd_inst, rd_rs1, rd_rs2} !== mq[0]) begin
          n_bad++; $display("FAIL rnd_head@%0d: got %h want %h", cyc, {rd_inst, rd_rs1, rd_rs2}, mq[0]);
        end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_read();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
